// File: rtl/req_ack_mon_pkg.sv
// Shared types and constants for the req/ack handshake monitor.
// Error bit positions are fixed so software and benches can decode err_pulse/err_sticky.
package req_ack_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int NERR          = 6;
    localparam int ERR_SPURIOUS  = 0;
    localparam int ERR_EARLY     = 1;
    localparam int ERR_TIMEOUT   = 2;
    localparam int ERR_OVERLAP   = 3;
    localparam int ERR_REQ_WIDTH = 4;
    localparam int ERR_ACK_WIDTH = 5;

    // Width needed to hold a latency count of 0..max_lat.
    function automatic int calc_lat_w(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/req_ack_chan_mon.sv
// One monitored req/ack channel: edge detect, handshake FSM with latency counter,
// registered done/error pulses, sticky flags and a saturating error counter.
module req_ack_chan_mon
    import req_ack_mon_pkg::*;
#(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 5,
    parameter int CNT_W   = 16,
    parameter int LAT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             ack,
    input  logic             err_clr,
    output logic             done_vld,
    output logic [LAT_W-1:0] done_lat,
    output logic [NERR-1:0]  err_pulse,
    output logic [NERR-1:0]  err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output state_t           dbg_state
);

    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] ONE_L = LAT_W'(1);

    logic req_q, req_qq, ack_q, ack_qq;
    logic req_rise, ack_rise;

    state_t           state, state_n;
    logic [LAT_W-1:0] lat, lat_n;
    logic             done_n;
    logic [LAT_W-1:0] done_lat_n;
    logic [NERR-1:0]  err_n;

    assign req_rise  = req & ~req_q;
    assign ack_rise  = ack & ~ack_q;
    assign dbg_state = state;

    always_comb begin
        state_n    = state;
        lat_n      = lat;
        done_n     = 1'b0;
        done_lat_n = '0;
        err_n      = '0;
        case (state)
            IDLE: begin
                // Same-cycle req+ack is latency 0, so the ack is spurious.
                if (ack_rise) err_n[ERR_SPURIOUS] = 1'b1;
                if (req_rise) begin
                    state_n = WAIT;
                    lat_n   = ONE_L;
                end
            end
            WAIT: begin
                if (ack_rise) begin
                    if (lat < MIN_L) begin
                        err_n[ERR_EARLY] = 1'b1;
                    end else begin
                        done_n     = 1'b1;
                        done_lat_n = lat;
                    end
                    state_n = req_rise ? WAIT : IDLE;
                    lat_n   = req_rise ? ONE_L : '0;
                end else if (req_rise) begin
                    // A new req restarts timing, even on the last legal cycle.
                    err_n[ERR_OVERLAP] = 1'b1;
                    lat_n              = ONE_L;
                end else if (lat == MAX_L) begin
                    err_n[ERR_TIMEOUT] = 1'b1;
                    state_n            = IDLE;
                    lat_n              = '0;
                end else begin
                    lat_n = lat + ONE_L;
                end
            end
            default: begin
                state_n = IDLE;
                lat_n   = '0;
            end
        endcase
        err_n[ERR_REQ_WIDTH] = req & req_q & ~req_qq;
        err_n[ERR_ACK_WIDTH] = ack & ack_q & ~ack_qq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= 1'b0;
            req_qq     <= 1'b0;
            ack_q      <= 1'b0;
            ack_qq     <= 1'b0;
            state      <= IDLE;
            lat        <= '0;
            done_vld   <= 1'b0;
            done_lat   <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
            err_cnt    <= '0;
        end else begin
            req_q     <= req;
            req_qq    <= req_q;
            ack_q     <= ack;
            ack_qq    <= ack_q;
            state     <= state_n;
            lat       <= lat_n;
            done_vld  <= done_n;
            done_lat  <= done_lat_n;
            err_pulse <= err_n;
            if (err_clr) begin
                err_sticky <= '0;
                err_cnt    <= '0;
            end else begin
                err_sticky <= err_sticky | err_n;
                if ((|err_n) && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/req_ack_mon.sv
// Passive multi-channel req/ack handshake monitor: NUM_CH independent channel
// monitors with flattened outputs and a global sticky-error summary.
module req_ack_mon
    import req_ack_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 5,
    parameter int CNT_W   = 16,
    localparam int LAT_W  = calc_lat_w(MAX_LAT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        ack,
    input  logic                     err_clr,
    output logic [NUM_CH-1:0]        done_vld,
    output logic [NUM_CH*LAT_W-1:0]  done_lat,
    output logic [NUM_CH*NERR-1:0]   err_pulse,
    output logic [NUM_CH*NERR-1:0]   err_sticky,
    output logic [NUM_CH*CNT_W-1:0]  err_cnt,
    output logic                     err_any,
    output logic [NUM_CH-1:0]        dbg_state
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("req_ack_mon: NUM_CH must be >= 1");
    end
    if (MIN_LAT < 1) begin : g_bad_min_lat
        $error("req_ack_mon: MIN_LAT must be >= 1");
    end
    if (MAX_LAT < MIN_LAT) begin : g_bad_max_lat
        $error("req_ack_mon: MAX_LAT must be >= MIN_LAT");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t st;

        req_ack_chan_mon #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT),
            .CNT_W   (CNT_W),
            .LAT_W   (LAT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .req        (req[c]),
            .ack        (ack[c]),
            .err_clr    (err_clr),
            .done_vld   (done_vld[c]),
            .done_lat   (done_lat[c*LAT_W +: LAT_W]),
            .err_pulse  (err_pulse[c*NERR +: NERR]),
            .err_sticky (err_sticky[c*NERR +: NERR]),
            .err_cnt    (err_cnt[c*CNT_W +: CNT_W]),
            .dbg_state  (st)
        );

        // 1 while the channel has an open transaction.
        assign dbg_state[c] = (st == WAIT);
    end

    assign err_any = |err_sticky;

endmodule

// File: tb/tb_req_ack_mon.sv
// Bench for req_ack_mon: directed scenarios with literal expectations plus random
// traffic checked every cycle against a timestamp-based model of the handshake rules.
module tb_req_ack_mon;
    import req_ack_mon_pkg::*;

    localparam int N     = 4;
    localparam int MINL  = 2;
    localparam int MAXL  = 5;
    localparam int CW    = 4;
    localparam int LW    = calc_lat_w(MAXL);
    localparam int NE    = NERR;
    localparam int OUT_W = N + 1 + N*CW + 2*N*NE + N*LW + N;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, ack;
    logic              err_clr;
    logic [N-1:0]      done_vld;
    logic [N*LW-1:0]   done_lat;
    logic [N*NE-1:0]   err_pulse, err_sticky;
    logic [N*CW-1:0]   err_cnt;
    logic              err_any;
    logic [N-1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    req_ack_mon #(.NUM_CH(N), .MIN_LAT(MINL), .MAX_LAT(MAXL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .err_clr(err_clr),
        .done_vld(done_vld), .done_lat(done_lat), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .err_any(err_any),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A channel is "open" from its req edge; latency is edge-number difference.
    logic [OUT_W-1:0] exp_q[$];
    int   edge_no = 0;
    bit   m_open  [N];
    int   m_start [N];
    bit   p_req [N], p_req2 [N], p_ack [N], p_ack2 [N];
    logic [NE-1:0] m_stk [N];
    int   m_cnt [N];

    always @(posedge clk) begin
        logic [N-1:0]    o_done;
        logic [N*LW-1:0] o_lat;
        logic [N*NE-1:0] o_err, o_stk;
        logic [N*CW-1:0] o_cnt;
        logic [N-1:0]    o_open;
        logic [NE-1:0]   errs;
        bit rr, ar;
        int age;
        edge_no++;
        o_done = '0; o_lat = '0; o_err = '0; o_stk = '0; o_cnt = '0; o_open = '0;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_open[c] = 0; m_stk[c] = '0; m_cnt[c] = 0;
                p_req[c] = 0; p_req2[c] = 0; p_ack[c] = 0; p_ack2[c] = 0;
            end else begin
                errs = '0;
                rr = req[c] && !p_req[c];
                ar = ack[c] && !p_ack[c];
                if (!m_open[c]) begin
                    if (ar) errs[ERR_SPURIOUS] = 1'b1;
                    if (rr) begin m_open[c] = 1; m_start[c] = edge_no; end
                end else begin
                    age = edge_no - m_start[c];
                    if (ar) begin
                        if (age < MINL) errs[ERR_EARLY] = 1'b1;
                        else begin o_done[c] = 1'b1; o_lat[c*LW +: LW] = LW'(age); end
                        m_open[c] = rr;
                        m_start[c] = edge_no;
                    end else if (rr) begin
                        errs[ERR_OVERLAP] = 1'b1;
                        m_start[c] = edge_no;
                    end else if (age >= MAXL) begin
                        errs[ERR_TIMEOUT] = 1'b1;
                        m_open[c] = 0;
                    end
                end
                errs[ERR_REQ_WIDTH] = req[c] && p_req[c] && !p_req2[c];
                errs[ERR_ACK_WIDTH] = ack[c] && p_ack[c] && !p_ack2[c];
                if (err_clr) begin
                    m_stk[c] = '0; m_cnt[c] = 0;
                end else begin
                    m_stk[c] = m_stk[c] | errs;
                    if (errs != '0 && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
                end
                o_err[c*NE +: NE] = errs;
                p_req2[c] = p_req[c]; p_req[c] = req[c];
                p_ack2[c] = p_ack[c]; p_ack[c] = ack[c];
            end
            o_stk[c*NE +: NE] = m_stk[c];
            o_cnt[c*CW +: CW] = CW'(m_cnt[c]);
            o_open[c]         = m_open[c];
        end
        exp_q.push_back({o_open, |o_stk, o_cnt, o_stk, o_err, o_lat, o_done});
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        logic [OUT_W-1:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {dbg_state, err_any, err_cnt, err_sticky, err_pulse, done_lat, done_vld};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model @t=%0t act=%h exp=%h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- driver / directed helpers ----------------
    task automatic tick_drive(input logic [N-1:0] r, input logic [N-1:0] a);
        @(negedge clk);
        req = r;
        ack = a;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NE-1:0] ep(input int c);
        return err_pulse[c*NE +: NE];
    endfunction

    function automatic logic [LW-1:0] dl(input int c);
        return done_lat[c*LW +: LW];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int width_cnt;
        logic [N-1:0] acc_done;
        logic [N*NE-1:0] acc_err;
        logic [N-1:0] r, a;

        rst = 1'b1; err_clr = 1'b0; req = '0; ack = '0;
        tick_drive('0, '0);
        chk("reset_done_vld", 64'(done_vld), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        chk("reset_err_any", 64'(err_any), 64'd0);
        tick_drive('0, '0);
        rst = 1'b0;
        repeat (3) tick_drive('0, '0);

        // ch0 legal handshake, latency 2
        tick_drive(4'b0001, '0);
        tick_drive('0, '0);
        tick_drive('0, 4'b0001);
        tick_drive('0, '0);
        chk("ch0_done_vld", 64'(done_vld), 64'b0001);
        chk("ch0_done_lat", 64'(dl(0)), 64'd2);
        chk("ch0_no_err", 64'(err_pulse), 64'd0);

        // ch1 latency 5 (max legal)
        tick_drive(4'b0010, '0);
        repeat (4) tick_drive('0, '0);
        tick_drive('0, 4'b0010);
        tick_drive('0, '0);
        chk("ch1_done_vld", 64'(done_vld), 64'b0010);
        chk("ch1_done_lat5", 64'(dl(1)), 64'd5);
        chk("ch1_no_err", 64'(err_pulse), 64'd0);

        // ch1 ack one cycle too late: timeout then spurious
        tick_drive(4'b0010, '0);
        repeat (5) tick_drive('0, '0);
        tick_drive('0, 4'b0010);
        chk("ch1_timeout", 64'(ep(1)), 64'(1 << ERR_TIMEOUT));
        tick_drive('0, '0);
        chk("ch1_spurious", 64'(ep(1)), 64'(1 << ERR_SPURIOUS));
        chk("ch1_err_cnt2", 64'(err_cnt[1*CW +: CW]), 64'd2);

        // ch3 early ack (latency 1 < MIN_LAT)
        tick_drive(4'b1000, '0);
        tick_drive('0, 4'b1000);
        tick_drive('0, '0);
        chk("ch3_early", 64'(ep(3)), 64'(1 << ERR_EARLY));
        chk("ch3_no_done", 64'(done_vld), 64'd0);

        // ch3 simultaneous req+ack rise while idle
        tick_drive(4'b1000, 4'b1000);
        tick_drive('0, '0);
        chk("ch3_simul_spurious", 64'(ep(3)), 64'(1 << ERR_SPURIOUS));
        repeat (8) tick_drive('0, '0);

        // ch2 overlap, then completion timed from the second req
        tick_drive(4'b0100, '0);
        tick_drive('0, '0);
        tick_drive(4'b0100, '0);
        tick_drive('0, '0);
        chk("ch2_overlap", 64'(ep(2)), 64'(1 << ERR_OVERLAP));
        tick_drive('0, 4'b0100);
        tick_drive('0, '0);
        chk("ch2_done_vld", 64'(done_vld), 64'b0100);
        chk("ch2_done_lat2", 64'(dl(2)), 64'd2);

        // ch2 req held 3 cycles: exactly one width error
        width_cnt = 0;
        for (int j = 0; j < 13; j++) begin
            tick_drive((j < 3) ? 4'b0100 : 4'b0000, '0);
            if (j > 0) width_cnt += int'(ep(2)[ERR_REQ_WIDTH]);
        end
        chk("ch2_req_width_once", 64'(width_cnt), 64'd1);

        // all channels concurrently, latencies 2..5
        tick_drive(4'b1111, '0);
        for (int j = 1; j <= 6; j++) begin
            a = '0;
            if (j >= 2 && j <= 5) a[j-2] = 1'b1;
            tick_drive('0, a);
            if (j >= 3) begin
                chk("conc_done_vld", 64'(done_vld), 64'(1 << (j - 3)));
                chk("conc_done_lat", 64'(dl(j - 3)), 64'(j - 1));
            end
        end
        tick_drive('0, '0);
        chk("sticky_set_err_any", 64'(err_any), 64'd1);

        // err_clr
        tick_drive('0, '0);
        err_clr = 1'b1;
        tick_drive('0, '0);
        err_clr = 1'b0;
        chk("clr_sticky", 64'(err_sticky), 64'd0);
        chk("clr_cnt", 64'(err_cnt), 64'd0);
        chk("clr_err_any", 64'(err_any), 64'd0);

        // reset mid-transaction drops it silently
        tick_drive(4'b0001, '0);
        tick_drive('0, '0);
        tick_drive('0, '0);
        rst = 1'b1;
        tick_drive('0, '0);
        rst = 1'b0;
        acc_done = '0; acc_err = '0;
        repeat (10) begin
            tick_drive('0, '0);
            acc_done |= done_vld;
            acc_err  |= err_pulse;
        end
        chk("rst_mid_no_err", 64'(acc_err), 64'd0);
        chk("rst_mid_no_done", 64'(acc_done), 64'd0);
        chk("rst_mid_state", 64'(dbg_state), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++) begin
                r[c] = ($urandom_range(0, 5) == 0);
                a[c] = ($urandom_range(0, 4) == 0);
            end
            tick_drive(r, a);
            err_clr = ($urandom_range(0, 60) == 0);
            rst     = ($urandom_range(0, 500) == 0);
        end
        rst = 1'b0; err_clr = 1'b0;
        repeat (10) tick_drive('0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_mon.md
# req_ack_mon

Synthesisable multi-channel monitor for single-pulse req/ack handshakes. It generalises the handshake rules the team applies in bench assertions into RTL that can ship in silicon and on emulation: N independent channels, a configurable ack latency window, per-channel error pulses, sticky flags and saturating counters, and a per-transaction latency report. It sits passively beside any req/ack interface and never drives the handshake.

## Interface
- NUM_CH, 4, number of independent req/ack channels (≥1)
- MIN_LAT, 1, minimum legal req→ack latency in cycles (≥1)
- MAX_LAT, 5, maximum legal req→ack latency in cycles (≥ MIN_LAT)
- CNT_W, 16, width of each per-channel error counter
- Derived: LAT_W = $clog2(MAX_LAT+1); NERR = 6
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CH  request per channel
- ack  in  NUM_CH  acknowledge per channel
- err_clr  in  1  clears all sticky flags and counters (synchronous)
- done_vld  out  NUM_CH  1-cycle pulse: legal handshake completed
- done_lat  out  NUM_CH*LAT_W  latency of completed handshake, valid with done_vld
- err_pulse  out  NUM_CH*NERR  1-cycle error pulses, channel c at bits [c*NERR +: NERR]
- err_sticky  out  NUM_CH*NERR  sticky OR of err_pulse
- err_cnt  out  NUM_CH*CNT_W  saturating count of cycles with any error, per channel
- err_any  out  1  OR of all err_sticky bits

## Operation
- Per channel, events are defined on sampled inputs: req_rise = req & !req_q, ack_rise = ack & !ack_q. req_q and ack_q reset to 0.
- States: IDLE, WAIT. lat counter width LAT_W.
- IDLE: req_rise → WAIT, lat := 1. ack_rise → ERR_SPURIOUS. This includes ack_rise in the same cycle as req_rise, because latency 0 is illegal.
- WAIT, ack_rise:
  - lat < MIN_LAT → ERR_EARLY, go to IDLE, no done_vld.
  - Otherwise → done_vld, done_lat := lat, go to IDLE.
- WAIT, no ack_rise, lat == MAX_LAT → ERR_TIMEOUT, go to IDLE.
- WAIT, no ack_rise, lat < MAX_LAT → lat := lat + 1.
- WAIT, req_rise without ack_rise → ERR_OVERLAP, stay in WAIT, lat := 1. Timing restarts from the new req.
- WAIT, req_rise and ack_rise in the same cycle → the old transaction completes under the ack rules above, and the new one starts with WAIT, lat := 1. No overlap error.
- ERR_REQ_WIDTH: req & req_q & !req_qq. Flagged once per stretched pulse, on its second high cycle.
- ERR_ACK_WIDTH: same rule applied to ack.
- Error bit index order: 0 SPURIOUS, 1 EARLY, 2 TIMEOUT, 3 OVERLAP, 4 REQ_WIDTH, 5 ACK_WIDTH. Several bits may pulse in one cycle.
- err_cnt increments by 1 in any cycle with any err_pulse bit set on that channel, and saturates at 2^CNT_W−1.
- err_clr: sticky flags and counters are 0 next cycle; pulses in the err_clr cycle are discarded. FSMs are unaffected.

## Timing
- Inputs are sampled at edge k. All outputs are registered and reflect edge-k events during cycle k+1.
- A legal handshake with req rising at edge t and ack rising at edge t+L reports done_vld=1, done_lat=L in cycle t+L+1.
- Timeout for req at edge t pulses in cycle t+MAX_LAT+1. An ack at t+MAX_LAT is still legal.
- Reset values: every output 0, all FSMs IDLE, req_q/ack_q/req_qq/ack_qq 0, lat 0.
- rst mid-transaction drops the transaction silently: no timeout and no error. If req or ack is high in the first cycle after reset, it is a rising edge.
- Channels are fully independent. There is no cross-channel arbitration.

## Structure
- Package req_ack_mon_pkg holds:
  - the state enum (IDLE, WAIT)
  - the error index localparams (ERR_SPURIOUS … ERR_ACK_WIDTH)
  - NERR
  - the LAT_W helper function
- Sub-module req_ack_chan_mon is one channel: edge registers, FSM, lat counter, sticky flags, counter. The top generates NUM_CH instances and ORs them into err_any.
- Elaboration checks: MIN_LAT ≥ 1, MAX_LAT ≥ MIN_LAT, NUM_CH ≥ 1.

## Test plan
- Default params, ch0: req pulse at edge 10, ack pulse at edge 12 → done_vld[0] in cycle 13 with done_lat=2; all err_pulse 0.
- ch1: req at edge 20, ack at edge 25 → done_lat=5, no error. Repeat with ack at edge 26 → ERR_TIMEOUT pulse in cycle 26, then ERR_SPURIOUS in cycle 27; err_cnt[1]=2.
- MIN_LAT=3: req at edge 5, ack at edge 6 → ERR_EARLY in cycle 7, no done_vld. Simultaneous req+ack rise in IDLE → ERR_SPURIOUS only.
- ch2: req at edge 5, req again at edge 7, ack at edge 9 → ERR_OVERLAP in cycle 8, done_lat=2 in cycle 10. Req held high 3 cycles → exactly one ERR_REQ_WIDTH pulse.
- All 4 channels active concurrently with different latencies → each done_lat is independent and correct. Assert err_clr → sticky, err_cnt and err_any are 0 next cycle. rst at edge t+2 of an open transaction → no error afterwards, all outputs 0.
